e_mdu: RTL and testbench

E_MDU -- requirements
Module: E_MDU

---
 rtl/e_mdu.sv | 125 ++++++++++++
 tb/tb_e_mdu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult (5 cycles) and div (10 cycles)
// with architectural HI/LO registers and mfhi/mflo/mthi/mtlo access.
module e_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [3:0]  mduOp,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] mduResult
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_b_zero;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_sq_mag;
  logic [31:0] w_sr_mag;
  logic [63:0] w_res;

  assign busy     = (r_state == S_RUN);
  assign w_is_mul = (mduOp == OP_MULT) || (mduOp == OP_MULTU);
  assign w_is_div = (mduOp == OP_DIV) || (mduOp == OP_DIVU);
  assign start    = (w_is_mul || w_is_div) && !req && !busy;

  always_comb begin
    mduResult = '0;
    if (mduOp == OP_MFHI) mduResult = r_hi;
    else if (mduOp == OP_MFLO) mduResult = r_lo;
  end

  // Signed divide is done on magnitudes and re-signed afterwards; this also
  // yields 0x80000000 / -1 = 0x80000000 rem 0 without special-casing.
  assign w_a_neg      = srcA[31];
  assign w_b_neg      = srcB[31];
  assign w_b_zero     = (srcB == 32'd0);
  assign w_a_mag      = w_a_neg ? (32'd0 - srcA) : srcA;
  assign w_b_mag      = w_b_neg ? (32'd0 - srcB) : srcB;
  assign w_b_safe_mag = w_b_zero ? 32'd1 : w_b_mag;
  assign w_b_safe     = w_b_zero ? 32'd1 : srcB;
  assign w_sq_mag     = w_a_mag / w_b_safe_mag;
  assign w_sr_mag     = w_a_mag % w_b_safe_mag;

  always_comb begin
    w_res = {r_hi, r_lo};
    case (mduOp)
      OP_MULT:  w_res = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
      OP_MULTU: w_res = {32'd0, srcA} * {32'd0, srcB};
      OP_DIV: begin
        if (!w_b_zero) begin
          w_res[31:0]  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_sq_mag) : w_sq_mag;
          w_res[63:32] = w_a_neg ? (32'd0 - w_sr_mag) : w_sr_mag;
        end
      end
      OP_DIVU: begin
        if (!w_b_zero) begin
          w_res[31:0]  = srcA / w_b_safe;
          w_res[63:32] = srcA % w_b_safe;
        end
      end
      default: w_res = {r_hi, r_lo};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pend_hi <= w_res[63:32];
            r_pend_lo <= w_res[31:0];
            r_cnt     <= w_is_mul ? 4'd5 : 4'd10;
            r_state   <= S_RUN;
          end else if (!req) begin
            if (mduOp == OP_MTHI) r_hi <= srcA;
            if (mduOp == OP_MTLO) r_lo <= srcA;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: latency, results, flush, reset behaviour.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [3:0]  mduOp;
  logic        req;
  logic        start;
  logic        busy;
  logic [31:0] mduResult;

  int checks;
  int errors;
  int n;

  e_mdu dut (
    .clk       (clk),
    .reset     (reset),
    .srcA      (srcA),
    .srcB      (srcB),
    .mduOp     (mduOp),
    .req       (req),
    .start     (start),
    .busy      (busy),
    .mduResult (mduResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive an op for one cycle, confirm start, then leave the bus at "none".
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mduOp = op;
    srcA  = a;
    srcB  = b;
    #1;
    chk("start_on_issue", {31'd0, start}, 32'd1);
    tick();
    mduOp = 4'd0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 30) begin
      cnt++;
      tick();
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    mduOp = 4'd5;
    #1;
    chk({tag, "_hi"}, mduResult, hi);
    mduOp = 4'd6;
    #1;
    chk({tag, "_lo"}, mduResult, lo);
    mduOp = 4'd0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    srcA   = '0;
    srcB   = '0;
    mduOp  = 4'd0;
    req    = 1'b0;

    #3 reset = 1'b0;
    #2;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    read_hilo("reset", 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Signed mult -2 * 3; req raised mid-run must not disturb it.
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    chk("mult_start_one_cycle", {31'd0, start}, 32'd0);
    req = 1'b1;
    count_busy(n);
    req = 1'b0;
    chk("mult_busy_cycles", n, 32'd5);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // Unsigned mult; ops issued while busy are ignored.
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    mduOp = 4'd2;
    #1;
    chk("no_start_while_busy", {31'd0, start}, 32'd0);
    mduOp = 4'd8;
    srcA  = 32'h0000_1234;
    count_busy(n);
    mduOp = 4'd0;
    chk("multu_busy_cycles", n, 32'd5);
    read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    // Signed div -7 / 2 with an mflo probe at busy cycle 4.
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      n++;
      if (n == 4) begin
        mduOp = 4'd6;
        #1;
        chk("mflo_during_div_old", mduResult, 32'hFFFF_FFFE);
        mduOp = 4'd0;
      end
      tick();
    end
    chk("div_busy_cycles", n, 32'd10);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    read_hilo("div_ovf", 32'h0000_0000, 32'h8000_0000);

    // mthi/mtlo then divu by zero leaves HI/LO alone.
    mduOp = 4'd7;
    srcA  = 32'h11;
    tick();
    mduOp = 4'd8;
    srcA  = 32'h22;
    tick();
    issue(4'd4, 32'd100, 32'd0);
    count_busy(n);
    chk("divu0_busy_cycles", n, 32'd10);
    read_hilo("divu0", 32'h11, 32'h22);

    issue(4'd4, 32'd100, 32'd7);
    count_busy(n);
    read_hilo("divu", 32'd2, 32'd14);

    mduOp = 4'd7;
    srcA  = 32'h11;
    tick();
    mduOp = 4'd8;
    srcA  = 32'h22;
    tick();

    // Flushed mult and flushed mtlo have no effect.
    mduOp = 4'd1;
    srcA  = 32'd5;
    srcB  = 32'd7;
    req   = 1'b1;
    #1;
    chk("req_start", {31'd0, start}, 32'd0);
    tick();
    chk("req_busy", {31'd0, busy}, 32'd0);
    mduOp = 4'd8;
    srcA  = 32'd5;
    tick();
    req = 1'b0;
    mduOp = 4'd0;
    read_hilo("req", 32'h11, 32'h22);

    // Reset at div busy cycle 6 discards the result and clears HI/LO.
    issue(4'd3, 32'd100, 32'd7);
    n = 1;
    while (busy === 1'b1 && n < 6) begin
      n++;
      tick();
    end
    chk("busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("busy_async_reset", {31'd0, busy}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    read_hilo("post_reset", 32'd0, 32'd0);
    issue(4'd1, 32'd3, 32'd4);
    count_busy(n);
    chk("post_reset_mult_cycles", n, 32'd5);
    read_hilo("post_reset_mult", 32'd0, 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
